udma_stream_tx_arbiter: RTL and testbench

//  Shares one L2 TX read channel (req/gnt address phase, valid/ready data phase) between
//  N_STREAMS stream units. Round-robin arbiter on the address phase; in-order ID FIFO

---
 rtl/udma_stream_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_udma_stream_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_stream_tx_arbiter.sv
// Round-robin arbiter sharing one L2 TX read channel between stream units.
// An in-order ID FIFO routes every returned word back to the unit that issued its read.
module udma_stream_tx_arbiter #(
  parameter int unsigned N_STREAMS       = 4,
  parameter int unsigned L2_AWIDTH_NOAL  = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                clr_i,
  input  logic [N_STREAMS-1:0]                req_i,
  input  logic [N_STREAMS*L2_AWIDTH_NOAL-1:0] addr_i,
  input  logic [N_STREAMS*2-1:0]              datasize_i,
  output logic [N_STREAMS-1:0]                gnt_o,
  output logic [N_STREAMS-1:0]                valid_o,
  output logic [DATA_WIDTH-1:0]               data_o,
  input  logic [N_STREAMS-1:0]                ready_i,
  output logic                                tx_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]           tx_addr_o,
  output logic [1:0]                          tx_datasize_o,
  input  logic                                tx_gnt_i,
  input  logic                                tx_valid_i,
  input  logic [DATA_WIDTH-1:0]               tx_data_i,
  output logic                                tx_ready_o,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned IDW  = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1;
  localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {StArb, StLock} state_e;

  state_e           state_q;
  logic [IDW-1:0]   prio_q;
  logic [IDW-1:0]   lock_q;
  logic             err_q;

  logic [IDW-1:0]   fifo_mem_q [MAX_OUTSTANDING];
  logic [PTRW-1:0]  wr_ptr_q;
  logic [PTRW-1:0]  rd_ptr_q;
  logic [CNTW-1:0]  count_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [IDW-1:0]   head;

  logic             arb_found;
  logic [IDW-1:0]   arb_idx;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   winner;
  logic             winner_req;
  logic             tx_req;
  logic             push;
  logic             pop;
  logic [IDW-1:0]   prio_nxt;

  assign fifo_full  = (count_q == CNTW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];

  // First requester at or after the current priority index, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_STREAMS; i++) begin
      cand = IDW'((32'(prio_q) + i) % N_STREAMS);
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    winner     = (state_q == StLock) ? lock_q : arb_idx;
    winner_req = (state_q == StLock) ? req_i[lock_q] : arb_found;
    tx_req     = winner_req & ~fifo_full & ~clr_i;
    push       = tx_req & tx_gnt_i;
    prio_nxt   = (winner == IDW'(N_STREAMS - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    gnt_o         = '0;
    tx_addr_o     = '0;
    tx_datasize_o = '0;
    if (push) gnt_o[winner] = 1'b1;
    for (int unsigned k = 0; k < N_STREAMS; k++) begin
      if (tx_req && (winner == IDW'(k))) begin
        tx_addr_o     = addr_i[k*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
        tx_datasize_o = datasize_i[k*2 +: 2];
      end
    end
  end

  // Clear drains the channel: accept and drop whatever word is in flight.
  always_comb begin
    valid_o    = '0;
    tx_ready_o = 1'b0;
    data_o     = '0;
    if (clr_i) begin
      tx_ready_o = 1'b1;
    end else if (!fifo_empty) begin
      valid_o[head] = tx_valid_i;
      tx_ready_o    = ready_i[head];
      data_o        = tx_data_i;
    end
    pop = ~clr_i & ~fifo_empty & tx_valid_i & tx_ready_o;
  end

  assign tx_req_o = tx_req;
  assign busy_o   = ~fifo_empty | (state_q == StLock);
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StArb;
      prio_q  <= '0;
      lock_q  <= '0;
    end else if (clr_i) begin
      state_q <= StArb;
      prio_q  <= '0;
      lock_q  <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (tx_req) begin
            if (tx_gnt_i) begin
              prio_q <= prio_nxt;
            end else begin
              lock_q  <= winner;
              state_q <= StLock;
            end
          end
        end
        StLock: begin
          // A dropped request releases the lock even while the FIFO is full.
          if (!req_i[lock_q]) begin
            state_q <= StArb;
          end else if (tx_req && tx_gnt_i) begin
            prio_q  <= prio_nxt;
            state_q <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= winner;
        wr_ptr_q <= (wr_ptr_q == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
      if (fifo_empty && tx_valid_i) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udma_stream_tx_arbiter.sv
// Bench for udma_stream_tx_arbiter: directed reset/fill/drain/clear sequence, then
// randomized traffic against a queue-based reference model.
module tb_udma_stream_tx_arbiter;

  localparam int N    = 4;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            clr;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N*2-1:0]  dsize;
  logic [N-1:0]    gnt;
  logic [N-1:0]    valid;
  logic [DW-1:0]   data;
  logic [N-1:0]    ready;
  logic            tx_req;
  logic [AW-1:0]   tx_addr;
  logic [1:0]      tx_ds;
  logic            tx_gnt;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_ready;
  logic            busy;
  logic            err;

  udma_stream_tx_arbiter #(
    .N_STREAMS      (N),
    .L2_AWIDTH_NOAL (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .clr_i        (clr),
    .req_i        (req),
    .addr_i       (addr),
    .datasize_i   (dsize),
    .gnt_o        (gnt),
    .valid_o      (valid),
    .data_o       (data),
    .ready_i      (ready),
    .tx_req_o     (tx_req),
    .tx_addr_o    (tx_addr),
    .tx_datasize_o(tx_ds),
    .tx_gnt_i     (tx_gnt),
    .tx_valid_i   (tx_valid),
    .tx_data_i    (tx_data),
    .tx_ready_o   (tx_ready),
    .busy_o       (busy),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of issuing unit IDs, a priority index and an optional lock.
  int m_q[$];
  int m_prio;
  bit m_locked;
  int m_lock;
  bit m_err;

  int e_win;
  bit e_txreq;
  logic [63:0] e_gnt, e_addr, e_ds, e_valid, e_ready, e_data, e_busy;

  task automatic model_reset();
    m_q.delete();
    m_prio   = 0;
    m_locked = 0;
    m_lock   = 0;
    m_err    = 0;
  endtask

  task automatic model_eval();
    bit wreq;
    bit full;
    full  = (m_q.size() == MAXO);
    e_win = 0;
    wreq  = 0;
    if (m_locked) begin
      e_win = m_lock;
      wreq  = req[m_lock];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!wreq && req[(m_prio + i) % N]) begin
          wreq  = 1;
          e_win = (m_prio + i) % N;
        end
      end
    end
    e_txreq = !clr && wreq && !full;
    e_gnt   = (e_txreq && tx_gnt) ? (64'd1 << e_win) : 64'd0;
    e_addr  = e_txreq ? 64'(addr[e_win*AW +: AW]) : 64'd0;
    e_ds    = e_txreq ? 64'(dsize[e_win*2 +: 2]) : 64'd0;
    e_valid = 0;
    e_ready = 0;
    e_data  = 0;
    if (clr) begin
      e_ready = 1;
    end else if (m_q.size() != 0) begin
      e_valid = tx_valid ? (64'd1 << m_q[0]) : 64'd0;
      e_ready = 64'(ready[m_q[0]]);
      e_data  = 64'(tx_data);
    end
    e_busy = 64'((m_q.size() != 0) || m_locked);
  endtask

  task automatic model_step();
    bit granted;
    if (clr) begin
      model_reset();
      return;
    end
    granted = (e_gnt != 0);
    if (m_q.size() == 0 && tx_valid) m_err = 1;
    if (m_q.size() != 0 && tx_valid && e_ready[0]) void'(m_q.pop_front());
    if (granted) m_q.push_back(e_win);
    if (m_locked) begin
      if (!req[m_lock]) m_locked = 0;
      else if (granted) m_locked = 0;
    end else if (e_txreq && !tx_gnt) begin
      m_locked = 1;
      m_lock   = e_win;
    end
    if (granted) m_prio = (e_win + 1) % N;
  endtask

  task automatic check_all();
    check("tx_req", 64'(tx_req), 64'(e_txreq));
    check("gnt", 64'(gnt), e_gnt);
    check("tx_addr", 64'(tx_addr), e_addr);
    check("tx_datasize", 64'(tx_ds), e_ds);
    check("valid", 64'(valid), e_valid);
    check("tx_ready", 64'(tx_ready), e_ready);
    check("data", 64'(data), e_data);
    check("busy", 64'(busy), e_busy);
    check("err", 64'(err), 64'(m_err));
  endtask

  task automatic idle_inputs();
    clr      = 0;
    req      = '0;
    addr     = '0;
    dsize    = '0;
    ready    = '0;
    tx_gnt   = 0;
    tx_valid = 0;
    tx_data  = '0;
  endtask

  initial begin
    rstn = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_req", 64'(tx_req), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);

    // Fill: all four units request with an always-granting channel.
    @(negedge clk);
    rstn   = 1;
    req    = 4'b1111;
    tx_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill_gnt", 64'(gnt), 64'd1 << i);
      @(negedge clk);
    end
    #1;
    check("full_tx_req", 64'(tx_req), 64'd0);
    check("full_busy", 64'(busy), 64'd1);

    // Drain in order; request reasserts once a slot frees, restarting at unit 0.
    @(negedge clk);
    tx_valid = 1;
    ready    = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tx_data = 32'hA0 + 32'(i);
      #1;
      check("drain_valid", 64'(valid), 64'd1 << i);
      check("drain_data", 64'(data), 64'hA0 + 64'(i));
      if (i == 0) check("drain_tx_req0", 64'(tx_req), 64'd0);
      if (i == 1) begin
        check("drain_tx_req1", 64'(tx_req), 64'd1);
        check("drain_regrant", 64'(gnt), 64'd1);
      end
      @(negedge clk);
    end

    // Clear with words outstanding, then provoke the sticky error.
    req      = '0;
    tx_gnt   = 0;
    tx_valid = 0;
    clr      = 1;
    #1;
    check("clr_tx_ready", 64'(tx_ready), 64'd1);
    check("clr_valid", 64'(valid), 64'd0);
    @(negedge clk);
    clr = 0;
    #1;
    check("post_clr_busy", 64'(busy), 64'd0);
    check("post_clr_err", 64'(err), 64'd0);
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    #1;
    check("err_set", 64'(err), 64'd1);
    @(negedge clk);
    #1;
    check("err_sticky", 64'(err), 64'd1);

    // Asynchronous reset, then randomized traffic against the model.
    rstn = 0;
    idle_inputs();
    #1;
    check("areset_err", 64'(err), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    model_reset();
    @(negedge clk);
    rstn = 1;
    repeat (3000) begin
      @(negedge clk);
      clr      = ($urandom_range(0, 63) == 0);
      req      = 4'($urandom_range(0, 15));
      addr     = {$urandom, $urandom};
      dsize    = 8'($urandom);
      ready    = 4'($urandom_range(0, 15));
      tx_gnt   = ($urandom_range(0, 2) != 0);
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = $urandom;
      #1;
      model_eval();
      check_all();
      @(posedge clk);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
